// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, write-back
// selects and the control bundle carried through the ID/EX register.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // mem_funct3 also carries the branch condition for BRANCH instructions
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
    alu_op_e    alu_op;
    logic       alu_src_pc;
    logic       alu_src_imm;
    logic       branch;
    logic       jump;
    logic [1:0] wb_sel;
  } ctrl_t;

  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write-back bypass,
// one synchronous write port, x0 hardwired to zero.
module regfile #(
  parameter bit RegInitZero = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      if (RegInitZero) begin
        for (int i = 0; i < 32; i++) regs[i] <= '0;
      end
    end else if (wb_en && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Bypass lets an instruction see a result retiring in the same cycle
  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 :
                    (wb_en && wb_addr == rs1_addr) ? wb_data : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 :
                    (wb_en && wb_addr == rs2_addr) ? wb_data : regs[rs2_addr];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, operand read and the ID/EX
// pipeline register with flush/stall squashing.
module decode_stage
  import riscv_pkg::*;
#(
  parameter bit RegInitZero = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output ctrl_t       ctrl_o,
  output logic        valid_o,
  output logic        illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  ctrl_t       d_ctrl;
  logic [31:0] d_imm;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_valid, d_illegal;
  logic [31:0] rs1_val, rs2_val;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Register indices an instruction does not use stay 0 so forwarding never matches them
  always_comb begin
    d_ctrl    = '0;
    d_imm     = '0;
    d_rs1     = '0;
    d_rs2     = '0;
    d_rd      = '0;
    d_valid   = 1'b0;
    d_illegal = 1'b0;
    if (valid_i && instr_i != 32'd0) begin
      d_valid = 1'b1;
      case (opcode)
        OP_LUI: begin
          d_ctrl.reg_write = 1'b1; d_ctrl.alu_src_imm = 1'b1; d_ctrl.alu_op = ALU_PASS_B;
          d_imm = imm_u; d_rd = instr_i[11:7];
        end
        OP_AUIPC: begin
          d_ctrl.reg_write = 1'b1; d_ctrl.alu_src_pc = 1'b1; d_ctrl.alu_src_imm = 1'b1;
          d_imm = imm_u; d_rd = instr_i[11:7];
        end
        OP_JAL: begin
          d_ctrl.reg_write = 1'b1; d_ctrl.jump = 1'b1; d_ctrl.wb_sel = WB_PC4;
          d_ctrl.alu_src_pc = 1'b1; d_ctrl.alu_src_imm = 1'b1;
          d_imm = imm_j; d_rd = instr_i[11:7];
        end
        OP_JALR: begin
          d_ctrl.reg_write = 1'b1; d_ctrl.jump = 1'b1; d_ctrl.wb_sel = WB_PC4;
          d_ctrl.alu_src_imm = 1'b1;
          d_imm = imm_i; d_rd = instr_i[11:7]; d_rs1 = instr_i[19:15];
        end
        OP_BRANCH: begin
          d_ctrl.branch = 1'b1; d_ctrl.mem_funct3 = funct3;
          case (funct3[2:1])
            2'b10:   d_ctrl.alu_op = ALU_SLT;
            2'b11:   d_ctrl.alu_op = ALU_SLTU;
            default: d_ctrl.alu_op = ALU_SUB;
          endcase
          d_imm = imm_b; d_rs1 = instr_i[19:15]; d_rs2 = instr_i[24:20];
        end
        OP_LOAD: begin
          d_ctrl.reg_write = 1'b1; d_ctrl.mem_read = 1'b1; d_ctrl.mem_funct3 = funct3;
          d_ctrl.alu_src_imm = 1'b1; d_ctrl.wb_sel = WB_MEM;
          d_imm = imm_i; d_rd = instr_i[11:7]; d_rs1 = instr_i[19:15];
        end
        OP_STORE: begin
          d_ctrl.mem_write = 1'b1; d_ctrl.mem_funct3 = funct3; d_ctrl.alu_src_imm = 1'b1;
          d_imm = imm_s; d_rs1 = instr_i[19:15]; d_rs2 = instr_i[24:20];
        end
        OP_IMM: begin
          d_ctrl.reg_write = 1'b1; d_ctrl.alu_src_imm = 1'b1;
          d_ctrl.alu_op = alu_from_funct3(funct3, funct3 == 3'b101 && instr_i[30]);
          d_imm = imm_i; d_rd = instr_i[11:7]; d_rs1 = instr_i[19:15];
        end
        OP_REG: begin
          d_ctrl.reg_write = 1'b1;
          d_ctrl.alu_op = alu_from_funct3(funct3, instr_i[30]);
          d_rd = instr_i[11:7]; d_rs1 = instr_i[19:15]; d_rs2 = instr_i[24:20];
        end
        default: d_illegal = 1'b1;
      endcase
    end
  end

  regfile #(.RegInitZero(RegInitZero)) u_regfile (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .rs1_addr (d_rs1),
    .rs2_addr (d_rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .wb_en    (wb_en_i),
    .wb_addr  (wb_addr_i),
    .wb_data  (wb_data_i)
  );

  // A stall inserts a bubble; fetch holds the instruction so it re-decodes next cycle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i || flush_i || stall_i) begin
      if (!rstn_i || flush_i || stall_i) begin
        pc_o       <= '0;
        rs1_data_o <= '0;
        rs2_data_o <= '0;
        imm_o      <= '0;
        rs1_addr_o <= '0;
        rs2_addr_o <= '0;
        rd_addr_o  <= '0;
        ctrl_o     <= '0;
        valid_o    <= 1'b0;
        illegal_o  <= 1'b0;
      end
    end else begin
      pc_o       <= d_valid ? pc_i : 32'd0;
      rs1_data_o <= rs1_val;
      rs2_data_o <= rs2_val;
      imm_o      <= d_imm;
      rs1_addr_o <= d_rs1;
      rs2_addr_o <= d_rs2;
      rd_addr_o  <= d_rd;
      ctrl_o     <= d_ctrl;
      valid_o    <= d_valid;
      illegal_o  <= d_illegal;
    end
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the RV32I core. It sits between fetch and execute and consumes the fetch stage's `pc_fetch`, `instr_o` and `update_o`. It holds the 32×32 register file, decodes the instruction into a control bundle and a sign-extended immediate, and reads both source operands with write-back bypass. All results are registered into the ID/EX pipeline register, which the hazard unit can squash on flush or stall.

## Interface
Parameters:
- `RegInitZero`, default 1: register file cleared to zero on reset.

Ports:
- `clk_i`  in  1  core clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `pc_i`  in  32  PC of the instruction, from fetch `pc_fetch`.
- `instr_i`  in  32  instruction word, from fetch `instr_o`.
- `valid_i`  in  1  fetch output is meaningful, from `update_o`.
- `stall_i`  in  1  hazard unit load-use stall.
- `flush_i`  in  1  hazard unit branch/jump flush.
- `wb_en_i`  in  1  write-back enable.
- `wb_addr_i`  in  5  write-back destination.
- `wb_data_i`  in  32  write-back data.
- `pc_o`  out  32  registered PC.
- `rs1_data_o`, `rs2_data_o`  out  32  registered operands.
- `imm_o`  out  32  registered sign-extended immediate.
- `rs1_addr_o`, `rs2_addr_o`, `rd_addr_o`  out  5  registered register indices, used for forwarding.
- `ctrl_o`  out  `ctrl_t`  registered control bundle.
- `valid_o`  out  1  ID/EX holds a real instruction.
- `illegal_o`  out  1  registered unknown-opcode flag.

## Operation
- **Decode** is combinational on `instr_i`, keyed on opcode [6:0]. Supported classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- **Immediate formats:**
  - I: `{{20{i[31]}}, i[31:20]}`
  - S: `{{20{i[31]}}, i[31:25], i[11:7]}`
  - B: `{{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}`
  - U: `{i[31:12], 12'b0}`
  - J: `{{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}`
  - R-type: 0.
- **`ctrl_t` fields:** `reg_write`, `mem_read`, `mem_write`, `mem_funct3[2:0]`, `alu_op[3:0]`, `alu_src_pc`, `alu_src_imm`, `branch`, `jump`, `wb_sel[1:0]` (ALU / MEM / PC+4).
- **Register file:**
  - 2 combinational read ports, 1 synchronous write port.
  - Writes to x0 are ignored; reads of x0 return 0.
  - Bypass: if `wb_en_i` is high, `wb_addr_i` equals the read index, and the index ≠ 0, the read returns `wb_data_i` in the same cycle.
- **Bubbles:**
  - An all-zero `instr_i` (fetch flush bubble) or `valid_i`=0 decodes as a bubble: `ctrl` all 0, `valid`=0, `illegal`=0.
  - An unknown opcode gives `ctrl` all 0, `valid`=1, `illegal`=1.
- **ID/EX update priority**, evaluated each clock:
  - `flush_i`: load bubble (all outputs 0).
  - `stall_i`: load bubble. Fetch holds `instr_i`, so the instruction is re-decoded next cycle with fresh register contents.
  - Otherwise: load the decoded values.
- Register-file write-back happens regardless of flush/stall.

## Timing
- Latency: exactly 1 cycle from `instr_i`/`pc_i` to all outputs.
- Reset (asynchronous, `rstn_i`=0):
  - all outputs 0, `valid_o`=0, `ctrl_o` all 0;
  - register file cleared when `RegInitZero`=1.
- Release from reset: the first edge with `rstn_i`=1 loads whatever decode presents.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge; any in-flight write-back is lost.
- `flush_i` and `stall_i` together: treated as flush.
- Write-back to the same register being read in that cycle: the new value is observed (bypass); the array updates at the same edge.
- A write-back landing during a stall cycle is visible on the retry, both through the array and through the bypass.

## Structure
- `riscv_pkg` holds:
  - `ctrl_t`;
  - opcode constants (`OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_IMM`, `OP_REG`);
  - the `alu_op` enumeration;
  - `wb_sel` encodings.
- Sub-module `regfile` contains the array, the x0 rule and the bypass. Decode logic and the ID/EX register live in `decode_stage`.

## Test plan
- `instr_i`=0x00500093 (addi x1,x0,5), `valid_i`=1 → next cycle: `rd_addr_o`=1, `imm_o`=5, `reg_write`=1, `alu_src_imm`=1, `valid_o`=1.
- `instr_i`=0xFE000CE3 (beq x0,x0,-8) → `imm_o`=0xFFFFFFF8, `branch`=1, `reg_write`=0.
- Write-back x3=0xDEADBEEF in the same cycle as `instr_i`=0x00018113 (addi x2,x3,0) → `rs1_data_o`=0xDEADBEEF. Then write-back x0=0x1234 followed by a read of x0 → 0.
- `flush_i`=1 with a valid ADD, and separately `stall_i`=1 with a valid ADD → `valid_o`=0 and `ctrl_o`=0 in both cases. For the stall, the held instruction decodes correctly on the next cycle.
- `instr_i`=0xFFFFFFFF → `illegal_o`=1, `ctrl_o`=0. `instr_i`=0 → `valid_o`=0, `illegal_o`=0.
- Assert `rstn_i` between clock edges after the pipeline has been filled → all outputs go to 0 before the next edge, and the register file reads 0.
